// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller.
//
// Holds the datapath word width and the divide micro-op opcodes seen on
// both the dispatch side and the divider side, plus small decode helpers
// so that every user classifies opcodes the same way.
package div_issue_ctrl_pkg;

    localparam int WORD_WIDTH = 32;

    // Opcodes understood by the divider itself are DIV and DIVU; REM and
    // REMU only exist on the dispatch side and select the remainder output.
    localparam logic [2:0] DIV_OP_DIV  = 3'd0;
    localparam logic [2:0] DIV_OP_DIVU = 3'd1;
    localparam logic [2:0] DIV_OP_REM  = 3'd2;
    localparam logic [2:0] DIV_OP_REMU = 3'd3;

    // True when the op wants the remainder rather than the quotient.
    function automatic logic divIsRem(input logic [2:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    // True when the op treats its operands as unsigned.
    function automatic logic divIsUnsigned(input logic [2:0] op);
        return (op == DIV_OP_DIVU) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request queue for the divider issue controller.
//
// Small synchronous FIFO with a clear input that empties it in one cycle.
// Read data is the current head and is valid whenever empty_o is low.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear_i    drop every stored entry (wins over push and pop)
//   push_i     write wdata_i at the tail (ignored when full)
//   wdata_i    entry to store
//   pop_i      discard the head entry (ignored when empty)
//   rdata_o    head entry
//   full_o     DEPTH entries stored
//   empty_o    no entries stored
module div_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];

    assign doPush = push_i && !full_o && !clear_i;
    assign doPop  = pop_i && !empty_o && !clear_i;

    // Pointer and occupancy bookkeeping. Pointers are PTR_W bits wide, so
    // they wrap around the power-of-two depth on their own.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (clear_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Requester-side controller for the iterative divider.
//
// Queues divide/remainder micro-ops from dispatch, launches them one at a
// time with a single-cycle div_start pulse, captures quotient or remainder
// when the divider finishes and offers the result on the CDB until granted.
// The divider cannot be killed, so a flush while an op is in flight waits
// in DRAIN for the finish and throws the result away.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        kill queued and in-flight ops
//   req_*                        dispatch valid/ready with op fields
//   div_start/opcode/operands    launch interface to the divider
//   div_quotient/remainder/finish  divider result interface
//   cdb_valid/tag/data, cdb_grant  result broadcast handshake
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_opcode,
    input  logic [WORD_WIDTH-1:0] req_src1,
    input  logic [WORD_WIDTH-1:0] req_src2,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  div_start,
    output logic [2:0]            div_opcode,
    output logic [WORD_WIDTH-1:0] div_divident,
    output logic [WORD_WIDTH-1:0] div_divisor,
    input  logic [WORD_WIDTH-1:0] div_quotient,
    input  logic [WORD_WIDTH-1:0] div_remainder,
    input  logic                  div_finish,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [WORD_WIDTH-1:0] cdb_data,
    input  logic                  cdb_grant
);

    localparam int ENTRY_W = 3 + 2 * WORD_WIDTH + TAG_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [TAG_W-1:0]      inFlightTag_q;
    logic                  inFlightIsRem_q;
    logic [TAG_W-1:0]      cdbTag_q, cdbTag_d;
    logic [WORD_WIDTH-1:0] cdbData_q, cdbData_d;
    logic                  captureEn;

    logic [ENTRY_W-1:0]    fifoWdata;
    logic [ENTRY_W-1:0]    fifoRdata;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoPush;
    logic                  launch;

    logic [2:0]            headOpcode;
    logic [WORD_WIDTH-1:0] headSrc1;
    logic [WORD_WIDTH-1:0] headSrc2;
    logic [TAG_W-1:0]      headTag;
    logic                  captureIsRem;

    assign fifoWdata  = {req_opcode, req_src1, req_src2, req_tag};
    assign headOpcode = fifoRdata[ENTRY_W-1 -: 3];
    assign headSrc1   = fifoRdata[TAG_W + 2 * WORD_WIDTH - 1 -: WORD_WIDTH];
    assign headSrc2   = fifoRdata[TAG_W + WORD_WIDTH - 1 -: WORD_WIDTH];
    assign headTag    = fifoRdata[TAG_W-1:0];

    // Accepting is blocked while draining so nothing new queues up behind
    // a result that is about to be thrown away.
    assign req_ready = !fifoFull && (state_q != ST_DRAIN);
    assign fifoPush  = req_valid && req_ready && !flush;

    // The head is read straight out of storage, so an op written this
    // cycle is not visible until the next one.
    assign launch = (state_q == ST_IDLE) && !fifoEmpty && !flush;

    div_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (fifoPush),
        .wdata_i (fifoWdata),
        .pop_i   (launch),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // The divider only knows signed and unsigned division; REM/REMU map
    // onto the same operation and pick the other result at capture.
    assign div_opcode   = divIsUnsigned(headOpcode) ? DIV_OP_DIVU : DIV_OP_DIV;
    assign div_divident = headSrc1;
    assign div_divisor  = headSrc2;

    // A same-cycle finish in IDLE belongs to the op being launched, whose
    // tag and kind are still at the queue head rather than in flight.
    assign captureIsRem = (state_q == ST_IDLE) ? divIsRem(headOpcode) : inFlightIsRem_q;
    assign cdbTag_d     = (state_q == ST_IDLE) ? headTag : inFlightTag_q;
    assign cdbData_d    = captureIsRem ? div_remainder : div_quotient;

    // Next-state and launch decode. Flush is checked first everywhere it
    // matters so it beats grant, finish and launch in the same cycle.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        captureEn = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    div_start = 1'b1;
                    if (div_finish) begin
                        captureEn = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = div_finish ? ST_IDLE : ST_DRAIN;
                end else if (div_finish) begin
                    captureEn = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || cdb_grant) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (div_finish && !flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, in-flight op identity and the held CDB result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            inFlightTag_q   <= '0;
            inFlightIsRem_q <= 1'b0;
            cdbTag_q        <= '0;
            cdbData_q       <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                inFlightTag_q   <= headTag;
                inFlightIsRem_q <= divIsRem(headOpcode);
            end
            if (captureEn) begin
                cdbTag_q  <= cdbTag_d;
                cdbData_q <= cdbData_d;
            end
        end
    end

    assign cdb_valid = (state_q == ST_DONE);
    assign cdb_tag   = cdbTag_q;
    assign cdb_data  = cdbData_q;

endmodule
